// File: rtl/gate_sched_pkg.sv
// Shared state encoding and default widths for the gate burst scheduler.
package gate_sched_pkg;

   localparam int GATE_NUMBER_DEFAULT = 8;
   localparam int CNT_W_DEFAULT       = 16;
   localparam int TMO_W_DEFAULT       = 12;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRIME = 3'd1,
      WAIT  = 3'd2,
      TICK  = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

endpackage

// File: rtl/gate_wait_timer.sv
// Per-tick wait counter; o_expire flags the last allowed WAIT cycle (limit 0 disables it).
module gate_wait_timer
   import gate_sched_pkg::*;
#(
   parameter int TMO_W = TMO_W_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [TMO_W-1:0] i_limit,
   output logic             o_expire
);

   logic [TMO_W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + TMO_W'(1);
      end
   end

   assign o_expire = (i_limit != '0) && (r_count == (i_limit - TMO_W'(1)));

endmodule

// File: rtl/gate_burst_scheduler.sv
// Burst sequencer for the gate array: runs burst_len gate clock ticks, each gated on gate readiness.
//   state | meaning
//   IDLE  | waiting for start, sync strobe high
//   PRIME | one cycle of tx_start before the first wait
//   WAIT  | waiting for all enabled gates ready, watchdog running
//   TICK  | gate clock + rx pull, tick counted
//   DONE  | one-cycle completion pulse
//   ERR   | watchdog fired, error captured on exit
module gate_burst_scheduler
   import gate_sched_pkg::*;
#(
   parameter int GATE_NUMBER = GATE_NUMBER_DEFAULT,
   parameter int CNT_W       = CNT_W_DEFAULT,
   parameter int TMO_W       = TMO_W_DEFAULT
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic                   i_abort,
   input  logic [CNT_W-1:0]       i_burst_len,
   input  logic [GATE_NUMBER-1:0] i_gate_mask,
   input  logic [TMO_W-1:0]       i_timeout,
   input  logic [GATE_NUMBER-1:0] i_tx_ready,
   input  logic [GATE_NUMBER-1:0] i_rx_ready,
   output logic                   o_gen_sync,
   output logic                   o_tx_start,
   output logic                   o_rx_pull,
   output logic                   o_clock,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_error,
   output logic [GATE_NUMBER-1:0] o_err_gate,
   output logic [CNT_W-1:0]       o_tick_count
);

   state_t                 r_state;
   logic [CNT_W-1:0]       r_tick_count;
   logic [CNT_W-1:0]       r_burst_len;
   logic [GATE_NUMBER-1:0] r_gate_mask;
   logic [TMO_W-1:0]       r_timeout;
   logic                   r_error;
   logic [GATE_NUMBER-1:0] r_err_gate;
   logic [GATE_NUMBER-1:0] r_err_cap;

   logic [GATE_NUMBER-1:0] w_both_ready;
   logic                   w_all_ready;
   logic                   w_expire;

   assign w_both_ready = i_tx_ready & i_rx_ready;
   assign w_all_ready  = &(w_both_ready | ~r_gate_mask);

   gate_wait_timer #(
      .TMO_W (TMO_W)
   ) u_wait_timer (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clear  (r_state != WAIT),
      .i_enable (r_state == WAIT),
      .i_limit  (r_timeout),
      .o_expire (w_expire)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_tick_count <= '0;
         r_burst_len  <= '0;
         r_gate_mask  <= '0;
         r_timeout    <= '0;
         r_error      <= 1'b0;
         r_err_gate   <= '0;
         r_err_cap    <= '0;
      end else if (i_abort && (r_state != IDLE)) begin
         // an aborted TICK still issued its clock pulse, so it is counted
         if (r_state == TICK) begin
            r_tick_count <= r_tick_count + CNT_W'(1);
         end
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start && !i_abort) begin
                  r_burst_len  <= i_burst_len;
                  r_gate_mask  <= i_gate_mask;
                  r_timeout    <= i_timeout;
                  r_tick_count <= '0;
                  r_error      <= 1'b0;
                  r_err_gate   <= '0;
                  r_state      <= (i_burst_len == '0) ? DONE : PRIME;
               end
            end
            PRIME: r_state <= WAIT;
            WAIT: begin
               if (w_all_ready) begin
                  r_state <= TICK;
               end else if (w_expire) begin
                  r_err_cap <= r_gate_mask & ~w_both_ready;
                  r_state   <= ERR;
               end
            end
            TICK: begin
               r_tick_count <= r_tick_count + CNT_W'(1);
               r_state      <= (r_tick_count == (r_burst_len - CNT_W'(1))) ? DONE : WAIT;
            end
            DONE: r_state <= IDLE;
            ERR: begin
               r_error    <= 1'b1;
               r_err_gate <= r_err_cap;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_gen_sync   = (r_state == IDLE);
   assign o_tx_start   = (r_state == PRIME) || (r_state == TICK);
   assign o_rx_pull    = (r_state == TICK);
   assign o_clock      = (r_state == TICK);
   assign o_busy       = (r_state != IDLE);
   assign o_done       = (r_state == DONE);
   assign o_error      = r_error;
   assign o_err_gate   = r_err_gate;
   assign o_tick_count = r_tick_count;

endmodule

// File: tb/tb_gate_burst_scheduler.sv
// Directed bench for gate_burst_scheduler with a per-cycle reference model and literal timing pins.
module tb_gate_burst_scheduler;

   localparam int G = 8;
   localparam int C = 16;
   localparam int T = 12;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [C-1:0] blen  = '0;
   logic [G-1:0] mask  = '0;
   logic [T-1:0] tmo   = '0;
   logic [G-1:0] txr   = '0;
   logic [G-1:0] rxr   = '0;

   logic         o_gen_sync, o_tx_start, o_rx_pull, o_clock, o_busy, o_done, o_error;
   logic [G-1:0] o_err_gate;
   logic [C-1:0] o_tick_count;
   logic [30:0]  dut_vec;

   localparam logic [30:0] RESET_VEC = 31'h4000_0000;

   gate_burst_scheduler #(.GATE_NUMBER(G), .CNT_W(C), .TMO_W(T)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_abort      (abort),
      .i_burst_len  (blen),
      .i_gate_mask  (mask),
      .i_timeout    (tmo),
      .i_tx_ready   (txr),
      .i_rx_ready   (rxr),
      .o_gen_sync   (o_gen_sync),
      .o_tx_start   (o_tx_start),
      .o_rx_pull    (o_rx_pull),
      .o_clock      (o_clock),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_error      (o_error),
      .o_err_gate   (o_err_gate),
      .o_tick_count (o_tick_count)
   );

   assign dut_vec = {o_gen_sync, o_tx_start, o_rx_pull, o_clock, o_busy, o_done, o_error,
                     o_err_gate, o_tick_count};

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: phase 0 idle, 1 prime, 2 wait, 3 tick, 4 done, 5 err
   int         m_mode  = 0;
   int         m_ticks = 0;
   int         m_len   = 0;
   int         m_stall = 0;
   int         m_tmo   = 0;
   logic [7:0] m_mask  = '0;
   logic [7:0] m_cap   = '0;
   logic [7:0] m_errg  = '0;
   bit         m_err   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_ticks = 0; m_len = 0; m_stall = 0; m_tmo = 0;
         m_mask = '0; m_cap = '0; m_errg = '0; m_err = 1'b0;
      end else if (abort && m_mode != 0) begin
         if (m_mode == 3) m_ticks++;
         m_mode = 0;
      end else begin
         case (m_mode)
            0: if (start && !abort) begin
               m_len = int'(blen); m_mask = mask; m_tmo = int'(tmo);
               m_ticks = 0; m_err = 1'b0; m_errg = '0;
               m_mode = (m_len == 0) ? 4 : 1;
            end
            1: begin m_mode = 2; m_stall = 0; end
            2: begin
               if (((txr & rxr) | ~m_mask) == 8'hFF) m_mode = 3;
               else if (m_tmo != 0 && m_stall + 1 == m_tmo) begin
                  m_cap = m_mask & ~(txr & rxr);
                  m_mode = 5;
               end else m_stall++;
            end
            3: begin
               m_ticks++;
               m_stall = 0;
               m_mode = (m_ticks == m_len) ? 4 : 2;
            end
            4: m_mode = 0;
            default: begin m_err = 1'b1; m_errg = m_cap; m_mode = 0; end
         endcase
      end
   end

   function automatic logic [30:0] model_vec();
      return {m_mode == 0, m_mode == 1 || m_mode == 3, m_mode == 3, m_mode == 3,
              m_mode != 0, m_mode == 4, m_err, m_errg, 16'(m_ticks)};
   endfunction

   always @(negedge clk) check("cycle_outputs", 64'(dut_vec), 64'(model_vec()));

   // Returns in cycle 1 after the start edge (cycle 0 = edge sampling start).
   task automatic start_burst(input int len, input logic [7:0] mk, input int to);
      @(negedge clk);
      start = 1'b1; blen = C'(len); mask = mk; tmo = T'(to);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Walks cycles from cyc0 until o_done or o_error is seen, bounded.
   task automatic run_until(input int cyc0, output int stop_cyc, output int clk_n,
                            output int first_clk, output int last_clk,
                            output bit tx_seen, output bit done_seen);
      int cyc = cyc0;
      stop_cyc = -1; clk_n = 0; first_clk = -1; last_clk = -1; tx_seen = 0; done_seen = 0;
      while (cyc < 300) begin
         if (o_clock) begin
            clk_n++;
            if (first_clk < 0) first_clk = cyc;
            last_clk = cyc;
         end
         if (o_tx_start) tx_seen = 1;
         if (o_done) done_seen = 1;
         if (o_done || o_error) begin
            stop_cyc = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  sc, cn, fc, lc;
      bit  txs, dn;

      repeat (2) @(negedge clk);
      check("reset_values", 64'(dut_vec), 64'(RESET_VEC));
      rst_n = 1'b1;
      txr = 8'hFF; rxr = 8'hFF;
      repeat (2) @(negedge clk);

      // burst of 3, always ready
      start_burst(3, 8'hFF, 0);
      run_until(1, sc, cn, fc, lc, txs, dn);
      check("b3_done_cycle", 64'(sc), 64'd8);
      check("b3_clock_pulses", 64'(cn), 64'd3);
      check("b3_first_clock", 64'(fc), 64'd3);
      check("b3_last_clock", 64'(lc), 64'd7);
      check("b3_tick_count", 64'(o_tick_count), 64'd3);
      repeat (2) @(negedge clk);

      // zero-length burst
      start_burst(0, 8'hFF, 0);
      run_until(1, sc, cn, fc, lc, txs, dn);
      check("b0_done_cycle", 64'(sc), 64'd1);
      check("b0_no_clock", 64'(cn), 64'd0);
      check("b0_no_tx_start", 64'(txs), 64'd0);
      check("b0_tick_count", 64'(o_tick_count), 64'd0);
      repeat (2) @(negedge clk);

      // gate 5 masked off and never ready: completes
      txr = 8'hDF;
      start_burst(2, 8'h0F, 4);
      run_until(1, sc, cn, fc, lc, txs, dn);
      check("mask_done_cycle", 64'(sc), 64'd6);
      check("mask_no_error", 64'(o_error), 64'd0);
      repeat (2) @(negedge clk);

      // gate 5 enabled: watchdog after 4 WAIT cycles
      start_burst(2, 8'hFF, 4);
      run_until(1, sc, cn, fc, lc, txs, dn);
      check("tmo_error_cycle", 64'(sc), 64'd7);
      check("tmo_error_flag", 64'(o_error), 64'd1);
      check("tmo_err_gate", 64'(o_err_gate), 64'h20);
      check("tmo_no_done", 64'(dn), 64'd0);
      check("tmo_no_clock", 64'(cn), 64'd0);
      repeat (3) @(negedge clk);
      check("tmo_error_sticky", 64'(o_error), 64'd1);

      // ready rises in the expiry cycle (timeout 3 -> WAIT cycles 2,3,4)
      start_burst(1, 8'hFF, 3);
      check("restart_clears_error", 64'(o_error), 64'd0);
      repeat (3) @(negedge clk);
      txr = 8'hFF;
      run_until(4, sc, cn, fc, lc, txs, dn);
      check("race_done_cycle", 64'(sc), 64'd6);
      check("race_clock_cycle", 64'(fc), 64'd5);
      @(negedge clk);
      check("race_no_error", 64'(o_error), 64'd0);
      repeat (2) @(negedge clk);

      // abort during WAIT of tick 2
      start_burst(5, 8'hFF, 0);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle", 64'(o_busy), 64'd0);
      check("abort_ticks", 64'(o_tick_count), 64'd1);
      check("abort_no_done", 64'(o_done), 64'd0);
      check("abort_no_error", 64'(o_error), 64'd0);
      start_burst(1, 8'hFF, 0);
      check("restart_clears_count", 64'(o_tick_count), 64'd0);
      run_until(1, sc, cn, fc, lc, txs, dn);
      check("b1_done_cycle", 64'(sc), 64'd4);
      repeat (2) @(negedge clk);

      // abort sampled in TICK still counts that tick
      start_burst(5, 8'hFF, 0);
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_tick_counts", 64'(o_tick_count), 64'd1);
      repeat (2) @(negedge clk);

      // start while busy is ignored, including its new configuration
      start_burst(3, 8'hFF, 0);
      @(negedge clk);
      start = 1'b1; blen = '0; mask = '0;
      @(negedge clk);
      start = 1'b0;
      run_until(3, sc, cn, fc, lc, txs, dn);
      check("busy_start_done_cycle", 64'(sc), 64'd8);
      check("busy_start_ticks", 64'(o_tick_count), 64'd3);
      repeat (2) @(negedge clk);

      // start with abort in IDLE is dropped
      @(negedge clk);
      start = 1'b1; abort = 1'b1; blen = C'(2);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("start_abort_dropped", 64'(o_busy), 64'd0);
      @(negedge clk);
      check("start_abort_still_idle", 64'(o_gen_sync), 64'd1);

      // async reset in the middle of a TICK
      start_burst(3, 8'hFF, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      check("pre_reset_in_tick", 64'(o_clock), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_values", 64'(dut_vec), 64'(RESET_VEC));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
